// File: rtl/mult_acc_pipe_if.sv
// Sample bus for mult_acc_pipe: operands and per-sample control in, product and
// running accumulator out.
//
// Handshake: valid-only, no ready. The source presents one sample per clock,
// qualified by valid_i. The block never stalls. valid_o pulses for one cycle
// when data_o/acc_o carry the result of a valid sample, and is otherwise 0.
interface mult_acc_pipe_if #(
  parameter int DATA_WIDTH_1 = 8,
  parameter int DATA_WIDTH_2 = 8,
  parameter int ACC_WIDTH    = 24
);
  logic                                 valid_i;
  logic [DATA_WIDTH_1-1:0]              data1_i;
  logic [DATA_WIDTH_2-1:0]              data2_i;
  logic                                 acc_en_i;
  logic                                 clr_i;
  logic [DATA_WIDTH_1+DATA_WIDTH_2-1:0] data_o;
  logic [ACC_WIDTH-1:0]                 acc_o;
  logic                                 valid_o;
  logic                                 ovf_o;

  modport master (
    output valid_i, data1_i, data2_i, acc_en_i, clr_i,
    input  data_o, acc_o, valid_o, ovf_o
  );

  modport slave (
    input  valid_i, data1_i, data2_i, acc_en_i, clr_i,
    output data_o, acc_o, valid_o, ovf_o
  );
endinterface

// File: rtl/mult_acc_pipe.sv
// Pipelined multiply-accumulate. Inputs are captured, then multiplied over
// PIPE_STAGES registers, then summed in a single-cycle accumulator stage.
module mult_acc_pipe #(
  parameter int DATA_WIDTH_1 = 8,
  parameter int DATA_WIDTH_2 = 8,
  parameter int PIPE_STAGES  = 2,
  parameter int ACC_WIDTH    = 24,
  parameter int SIGNED       = 0
) (
  input  logic            clk,
  input  logic            rst,
  mult_acc_pipe_if.slave  bus
);
  localparam int  PW        = DATA_WIDTH_1 + DATA_WIDTH_2;
  localparam int  EW        = ACC_WIDTH - PW;
  localparam bit  IS_SIGNED = (SIGNED != 0);

  // Capture register: operands and control sampled together.
  logic                    in_vld, in_en, in_clr;
  logic [DATA_WIDTH_1-1:0] in_a;
  logic [DATA_WIDTH_2-1:0] in_b;

  // Multiplier stages; index PIPE_STAGES-1 feeds the accumulator.
  logic [PIPE_STAGES-1:0]  st_vld, st_en, st_clr;
  logic [PW-1:0]           st_prod [PIPE_STAGES];

  logic [PW-1:0]           a_ext, b_ext, prod_c;
  logic [PW-1:0]           fin_prod;
  logic [ACC_WIDTH-1:0]    prod_ext;
  logic [ACC_WIDTH:0]      sum;
  logic                    ovf_step;

  logic [PW-1:0]           data_q;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic                    valid_q, ovf_q;

  // Operands widened to the product width, so the low PW bits of the
  // product are exact for both signed and unsigned arithmetic.
  generate
    if (IS_SIGNED) begin : g_sext_ops
      assign a_ext = {{DATA_WIDTH_2{in_a[DATA_WIDTH_1-1]}}, in_a};
      assign b_ext = {{DATA_WIDTH_1{in_b[DATA_WIDTH_2-1]}}, in_b};
    end else begin : g_zext_ops
      assign a_ext = {{DATA_WIDTH_2{1'b0}}, in_a};
      assign b_ext = {{DATA_WIDTH_1{1'b0}}, in_b};
    end
  endgenerate

  assign prod_c   = a_ext * b_ext;
  assign fin_prod = st_prod[PIPE_STAGES-1];

  generate
    if (EW > 0) begin : g_ext_prod
      assign prod_ext = {{EW{IS_SIGNED & fin_prod[PW-1]}}, fin_prod};
    end else begin : g_same_width
      assign prod_ext = fin_prod;
    end
  endgenerate

  assign sum = {1'b0, acc_q} + {1'b0, prod_ext};

  always_comb begin
    ovf_step = 1'b0;
    if (IS_SIGNED)
      ovf_step = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    else
      ovf_step = sum[ACC_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_vld <= 1'b0;
      in_en  <= 1'b0;
      in_clr <= 1'b0;
      in_a   <= '0;
      in_b   <= '0;
      st_vld <= '0;
      st_en  <= '0;
      st_clr <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) st_prod[i] <= '0;
    end else begin
      in_vld     <= bus.valid_i;
      in_en      <= bus.acc_en_i;
      in_clr     <= bus.clr_i;
      in_a       <= bus.data1_i;
      in_b       <= bus.data2_i;
      st_vld[0]  <= in_vld;
      st_en[0]   <= in_en;
      st_clr[0]  <= in_clr;
      st_prod[0] <= prod_c;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        st_vld[i]  <= st_vld[i-1];
        st_en[i]   <= st_en[i-1];
        st_clr[i]  <= st_clr[i-1];
        st_prod[i] <= st_prod[i-1];
      end
    end
  end

  // Accumulator stage: bubbles leave data, accumulator and overflow untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= st_vld[PIPE_STAGES-1];
      if (st_vld[PIPE_STAGES-1]) begin
        data_q <= fin_prod;
        if (st_clr[PIPE_STAGES-1]) begin
          acc_q <= st_en[PIPE_STAGES-1] ? prod_ext : '0;
          ovf_q <= 1'b0;
        end else if (st_en[PIPE_STAGES-1]) begin
          acc_q <= sum[ACC_WIDTH-1:0];
          ovf_q <= ovf_q | ovf_step;
        end
      end
    end
  end

  assign bus.data_o  = data_q;
  assign bus.acc_o   = acc_q;
  assign bus.valid_o = valid_q;
  assign bus.ovf_o   = ovf_q;
endmodule
